// File: rtl/pipemwreg_skid.sv
// pipemwreg_skid: MEM/WB pipeline register with valid/ready handshake, optional 2-entry skid and flush
module pipemwreg_skid #(
   parameter int DATA_W = 32,
   parameter int RN_W   = 5,
   parameter int SKID   = 1
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              mwreg,
   input  logic              mm2reg,
   input  logic [DATA_W-1:0] mmo,
   input  logic [DATA_W-1:0] malu,
   input  logic [RN_W-1:0]   mrn,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              wwreg,
   output logic              wm2reg,
   output logic [DATA_W-1:0] wmo,
   output logic [DATA_W-1:0] walu,
   output logic [RN_W-1:0]   wrn
);
   localparam int BW = 2 * DATA_W + RN_W + 2;
   logic [BW-1:0] in_b, out_b, skid_b;
   logic ov, sv, accept, drain;
   assign in_b      = {mwreg, mm2reg, mmo, malu, mrn};
   assign in_ready  = (SKID != 0) ? ~sv : (out_ready | ~ov);
   assign accept    = in_valid & in_ready;
   assign drain     = ov & out_ready;
   assign out_valid = ov;
   assign wwreg     = out_b[BW-1] & ov;
   assign wm2reg    = out_b[BW-2];
   assign wmo       = out_b[BW-3 -: DATA_W];
   assign walu      = out_b[RN_W +: DATA_W];
   assign wrn       = out_b[RN_W-1:0];
   // output entry and skid entry; a full skid always drains to the output before any new beat
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         ov     <= 1'b0;
         sv     <= 1'b0;
         out_b  <= '0;
         skid_b <= '0;
      end else if (flush) begin
         ov              <= 1'b0;
         sv              <= 1'b0;
         out_b[BW-1 -: 2] <= 2'b00;
      end else if (SKID == 0) begin
         if (accept) begin
            out_b <= in_b;
            ov    <= 1'b1;
         end else if (drain) ov <= 1'b0;
      end else if (sv) begin
         if (drain) begin
            out_b <= skid_b;
            sv    <= 1'b0;
         end
      end else if (accept & ov & ~drain) begin
         skid_b <= in_b;
         sv     <= 1'b1;
      end else if (accept) begin
         out_b <= in_b;
         ov    <= 1'b1;
      end else if (drain) ov <= 1'b0;
   end
endmodule
